// File: rtl/reg_bank_mp.sv
// Multi-port register bank: NRD combinational read ports, two prioritised write ports,
// sequential clear engine and registered debug tap. Optional same-cycle bypass: REG_BANK_BYPASS_EN.
module reg_bank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk_sig,
  input  logic                    rst_n_sig,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  input  logic                    wa_en,
  input  logic [ADDR_W-1:0]       wa_addr,
  input  logic [DATA_W-1:0]       wa_data,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (NRD < 1 || NRD > 4) begin : g_nrd_check
    $error("reg_bank_mp: NRD must be in the range 1..4");
  end

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   clr_ptr_q,  clr_ptr_d;
  logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                wa_wr;
  logic                wb_wr;

  assign clr_busy = (state_q == S_CLEAR);
  assign dbg_data = dbg_data_q;

  // Write qualifiers: dropped during clear and, with a hardwired zero entry, at address 0.
  assign wa_wr = wa_en && !clr_busy && !((ZERO_REG != 0) && (wa_addr == '0));
  assign wb_wr = wb_en && !clr_busy && !((ZERO_REG != 0) && (wb_addr == '0));

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clr_req) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Port B is applied last so it overrides port A on an address collision.
  always_comb begin
    mem_d = mem_q;
    if (clr_busy) begin
      mem_d[clr_ptr_q] = '0;
    end else begin
      if (wa_wr) mem_d[wa_addr] = wa_data;
      if (wb_wr) mem_d[wb_addr] = wb_data;
    end
  end

  assign dbg_data_d = clr_busy ? '0 : mem_q[dbg_addr];

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      state_q    <= S_CLEAR;
      clr_ptr_q  <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // NOTE: storage has no reset; the clear engine zeroes it after every reset release.
  always_ff @(posedge clk_sig) begin
    mem_q <= mem_d;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] lane;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      lane = '0;
      if (!rst_n_sig || clr_busy) begin
        lane = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        lane = '0;
      end else if (!rd_en[g]) begin
        lane = '0;
`ifdef REG_BANK_BYPASS_EN
      end else if (wb_wr && (wb_addr == addr)) begin
        lane = wb_data;
      end else if (wa_wr && (wa_addr == addr)) begin
        lane = wa_data;
`endif
      end else begin
        lane = mem_q[addr];
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = lane;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed self-checking bench for reg_bank_mp (DATA_W=32, ADDR_W=5, NRD=2, ZERO_REG=1).
// Expectations follow REG_BANK_BYPASS_EN when it is defined for the build.
module tb_reg_bank_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 2;
`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk_sig;
  logic              rst_n_sig;
  logic [N-1:0]      rd_en;
  logic [N*AW-1:0]   rd_addr;
  logic [N*DW-1:0]   rd_data;
  logic              wa_en, wb_en;
  logic [AW-1:0]     wa_addr, wb_addr;
  logic [DW-1:0]     wa_data, wb_data;
  logic              clr_req;
  logic              clr_busy;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;

  int n_vec = 0;
  int n_bad = 0;

  reg_bank_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(N), .ZERO_REG(1)) dut (
    .clk_sig  (clk_sig),
    .rst_n_sig(rst_n_sig),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wa_data  (wa_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  function automatic logic [DW-1:0] lane(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  // Inputs change on the falling edge; every comparison happens 1 time unit later.
  task automatic tick();
    @(negedge clk_sig);
  endtask

  initial begin
    int cnt;
    logic dirty;

    rst_n_sig = 1'b0;
    set_rd(2'b11, 5'd1, 5'd2);
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    clr_req = 1'b0; dbg_addr = 5'd1;

    // Reset state
    tick(); tick(); #1;
    check("rst_busy", 64'(clr_busy), 64'd1);
    check("rst_dbg",  64'(dbg_data), 64'd0);
    check("rst_rd",   64'(rd_data),  64'd0);

    // 1. Initial clear: exactly 32 busy cycles, outputs zero throughout
    tick(); rst_n_sig = 1'b1;
    cnt = 0; dirty = 1'b0;
    while (clr_busy && cnt < 100) begin
      #1;
      if (rd_data !== '0 || dbg_data !== '0) dirty = 1'b1;
      tick(); cnt++;
    end
    check("clr0_len",   64'(cnt),   64'd32);
    check("clr0_quiet", 64'(dirty), 64'd0);
    for (int a = 0; a < 32; a++) begin
      set_rd(2'b11, 5'(a), 5'(a)); #1;
      check($sformatf("clr0_r%0d", a), 64'(rd_data), 64'd0);
    end

    // 2. Single write with same-cycle and next-cycle read
    tick();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    set_rd(2'b01, 5'd5, 5'd0); #1;
    check("r5_same", 64'(lane(0)), BYP ? 64'hDEADBEEF : 64'd0);
    tick(); wa_en = 1'b0; #1;
    check("r5_next", 64'(lane(0)), 64'hDEADBEEF);

    // 3. Collision on r7: port B wins
    tick();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22222222;
    set_rd(2'b11, 5'd5, 5'd7); #1;
    check("r7_same", 64'(lane(1)), BYP ? 64'h22222222 : 64'd0);
    check("r5_hold", 64'(lane(0)), 64'hDEADBEEF);
    tick(); wa_en = 1'b0; wb_en = 1'b0; #1;
    check("r7_next", 64'(lane(1)), 64'h22222222);

    // Distinct addresses written on both ports in one cycle
    tick();
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h0000AAAA;
    wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h0000BBBB;
    set_rd(2'b11, 5'd10, 5'd11); #1;
    check("r10_same", 64'(lane(0)), BYP ? 64'h0000AAAA : 64'd0);
    check("r11_same", 64'(lane(1)), BYP ? 64'h0000BBBB : 64'd0);
    tick(); wa_en = 1'b0; wb_en = 1'b0; #1;
    check("r10_next", 64'(lane(0)), 64'h0000AAAA);
    check("r11_next", 64'(lane(1)), 64'h0000BBBB);

    // 4. Hardwired zero entry and read enables
    tick();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    set_rd(2'b11, 5'd0, 5'd0); #1;
    check("r0_same", 64'(rd_data), 64'd0);
    tick(); wa_en = 1'b0; #1;
    check("r0_next", 64'(rd_data), 64'd0);
    tick();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; #1;
    check("r0_wb_same", 64'(rd_data), 64'd0);
    tick(); wb_en = 1'b0; #1;
    check("r0_wb_next", 64'(rd_data), 64'd0);
    set_rd(2'b10, 5'd5, 5'd5); #1;
    check("en_p0_off", 64'(rd_data), {32'hDEADBEEF, 32'h0});
    set_rd(2'b01, 5'd5, 5'd5); #1;
    check("en_p1_off", 64'(rd_data), {32'h0, 32'hDEADBEEF});

    // 5. Fill r1..r3, then request clear with a dropped write and a second request
    tick();
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'd1;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd2;
    tick();
    wb_en = 1'b0;
    wa_addr = 5'd3; wa_data = 32'd3;
    tick(); wa_en = 1'b0;
    set_rd(2'b11, 5'd1, 5'd2); #1;
    check("fill_r1r2", 64'(rd_data), {32'd2, 32'd1});
    set_rd(2'b11, 5'd3, 5'd3); #1;
    check("fill_r3", 64'(lane(0)), 64'd3);
    dbg_addr = 5'd1;
    tick(); #1;
    check("dbg_r1", 64'(dbg_data), 64'd1);

    clr_req = 1'b1;
    tick(); clr_req = 1'b0;
    set_rd(2'b11, 5'd3, 5'd1);
    wa_addr = 5'd4; wa_data = 32'h44;
    cnt = 0; dirty = 1'b0;
    while (clr_busy && cnt < 100) begin
      wa_en   = (cnt == 20);
      clr_req = (cnt == 10);
      #1;
      if (rd_data !== '0) dirty = 1'b1;
      if (cnt > 0 && dbg_data !== '0) dirty = 1'b1;
      tick(); cnt++;
    end
    wa_en = 1'b0; clr_req = 1'b0;
    check("clr1_len",   64'(cnt),   64'd32);
    check("clr1_quiet", 64'(dirty), 64'd0);
    for (int a = 1; a <= 4; a++) begin
      set_rd(2'b11, 5'(a), 5'(a)); #1;
      check($sformatf("clr1_r%0d", a), 64'(rd_data), 64'd0);
    end

    // 6. Reset pulse at clear cycle 10 restarts the full clear
    clr_req = 1'b1;
    tick(); clr_req = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 10) begin
      tick(); cnt++;
    end
    check("clr2_reach10", 64'(cnt), 64'd10);
    rst_n_sig = 1'b0; #1;
    check("rst2_busy", 64'(clr_busy), 64'd1);
    check("rst2_dbg",  64'(dbg_data), 64'd0);
    check("rst2_rd",   64'(rd_data),  64'd0);
    tick(); rst_n_sig = 1'b1;
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      tick(); cnt++;
    end
    check("clr2_len", 64'(cnt), 64'd32);

    // Debug tap: one-cycle latency, blind to the same-cycle write
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5;
    dbg_addr = 5'd9;
    tick(); wb_en = 1'b0; #1;
    check("dbg_r9_stale", 64'(dbg_data), 64'd0);
    tick(); #1;
    check("dbg_r9", 64'(dbg_data), 64'hA5);
    set_rd(2'b11, 5'd9, 5'd9); #1;
    check("rd_r9", 64'(rd_data), {32'hA5, 32'hA5});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
- Parametrised multi-port register bank. It is the next generation of the core's single-write, two-read register bank.
- Provides NRD read ports, two write ports with fixed priority, and an optional hardwired zero entry.
- Includes a sequential clear engine that initialises storage after reset or on request, plus a registered debug tap.
- Sits in the decode/writeback stage of the pipelined CPU. Port A serves ALU writeback and port B serves load writeback.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk_sig  in  1  clock, rising edge
rst_n_sig  in  1  asynchronous active-low reset
rd_en  in  NRD  per-port read enable
rd_addr  in  NRD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  packed read data, combinational
wa_en  in  1  write port A enable
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
clr_req  in  1  request full clear, single-cycle pulse
clr_busy  out  1  clear engine active
dbg_addr  in  ADDR_W  debug tap address
dbg_data  out  DATA_W  registered debug tap data

Behaviour:
- Storage is DEPTH x DATA_W flops. The storage itself is not reset; the clear engine zeroes it.
- Reset asserted (rst_n_sig=0), asynchronous:
  - FSM goes to CLEAR with clr_ptr=0.
  - clr_busy=1, dbg_data=0.
  - All rd_data lanes read 0.
- Clear FSM:
  - States: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to entry clr_ptr, then clr_ptr+1.
  - When clr_ptr==DEPTH-1 the FSM moves to IDLE on that edge; clr_ptr wraps to 0.
  - A full clear takes exactly DEPTH cycles from reset deassertion.
  - IDLE: clr_req=1 moves the FSM to CLEAR next edge, clr_busy=1 from that edge.
  - clr_req during CLEAR is ignored; no restart and no extension.
  - clr_busy=1 exactly while in CLEAR.
- Writes:
  - Committed on the rising edge when the FSM is IDLE.
  - wa_en/wb_en are ignored during CLEAR; the writes are dropped, not queued.
  - If wa_en && wb_en && wa_addr==wb_addr, port B wins and port A is dropped.
  - If ZERO_REG=1, writes to address 0 are dropped.
- Reads, port i, combinational, priority order:
  1. Reset asserted or clr_busy=1 -> 0.
  2. ZERO_REG=1 and addr==0 -> 0.
  3. rd_en[i]=0 -> 0. Driven low, never Z.
  4. Bypass hit, if compiled in (see Optional Feature).
  5. Otherwise storage[addr].
- Debug tap:
  - dbg_data <= storage[dbg_addr] on every edge, so latency is 1 cycle.
  - dbg_data <= 0 while clr_busy.
  - The tap does not see same-cycle writes.
- Widths: all addresses are full range, with no out-of-range case because DEPTH=2**ADDR_W. NRD outside 1..4 is illegal; elaboration stops via a generate-time check.
- Reset mid-clear restarts the clear from entry 0.

Optional Feature:
REG_BANK_BYPASS_EN
- Defined: a read of address X in the same cycle as an enabled, IDLE-state write to X returns the write data.
  - Port B data has priority over port A.
  - Bypass never applies to address 0 when ZERO_REG=1.
- Undefined: a read returns the pre-write storage value; new data is visible from the next cycle.
- The macro does not affect the debug tap, the clear engine or the write rules.

Test Plan:
1. Release reset; count cycles until clr_busy falls -> exactly 32 cycles (DEPTH=32). All reads and dbg_data are 0 throughout; all entries read 0 afterwards.
2. IDLE: wa writes 0xDEADBEEF to r5. Next cycle, rd port 0 at addr 5 -> 0xDEADBEEF. Same-cycle read -> 0xDEADBEEF with bypass, old value (0) without.
3. Same cycle: wa (r7, 0x11111111) and wb (r7, 0x22222222). Next cycle r7 reads 0x22222222. Same cycle with bypass -> 0x22222222.
4. Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> r0 reads 0 on all ports, including during the bypass cycle. rd_en=0 on any port -> lane reads 0.
5. Fill r1..r3 with 1, 2, 3, then pulse clr_req:
   - clr_busy is high for 32 cycles.
   - A wa write to r4 mid-clear is dropped, so r4 reads 0 after the clear.
   - A second clr_req mid-clear does not extend the clear.
   - r1..r3 read 0 afterwards.
6. Assert rst_n_sig low for 1 cycle at clear cycle 10 -> clr_busy stays high and the full 32-cycle clear restarts. After a write to r9 = 0xA5, dbg_addr=9 gives dbg_data=0xA5 one cycle later.
